// File: rtl/seq_pkg.sv
// seq_pkg: constants shared by the pattern generator and the sequence
// detectors.
//   - SEQ_PAT_W / SEQ_REP_W : default pattern width and repetition-count width
//   - STATE_W, ST_*         : one-hot FSM state encodings and their bit positions
//   - seq_idx_w()           : width of a bit index into a PAT_W-wide pattern
// Optional feature macro: SEQ_GEN_GAP_EN adds the one-hot GAP state, which
// separates consecutive repetitions by one idle cycle.
package seq_pkg;

    localparam int SEQ_PAT_W = 8;
    localparam int SEQ_REP_W = 4;

    localparam int ST_IDLE_B  = 0;
    localparam int ST_SHIFT_B = 1;
    localparam int ST_DONE_B  = 2;

`ifdef SEQ_GEN_GAP_EN
    localparam int STATE_W   = 4;
    localparam int ST_GAP_B  = 3;
    localparam logic [STATE_W-1:0] ST_GAP = STATE_W'(1) << ST_GAP_B;
`else
    localparam int STATE_W   = 3;
`endif

    localparam logic [STATE_W-1:0] ST_IDLE  = STATE_W'(1) << ST_IDLE_B;
    localparam logic [STATE_W-1:0] ST_SHIFT = STATE_W'(1) << ST_SHIFT_B;
    localparam logic [STATE_W-1:0] ST_DONE  = STATE_W'(1) << ST_DONE_B;

    // A 1-bit pattern still needs a 1-bit index signal.
    function automatic int seq_idx_w(input int pat_w);
        return (pat_w > 1) ? $clog2(pat_w) : 1;
    endfunction

endpackage

// File: rtl/seq_bit_cnt.sv
// seq_bit_cnt: bit-position and remaining-repetition counters.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : start a new emission (loads load_len_m1 / load_rep)
//   advance      : one pattern bit is emitted this cycle
//   load_len_m1  : clamped length-1 of the pattern being loaded
//   len_m1       : clamped length-1 of the stored pattern (wrap reload value)
//   load_rep     : repetition count being loaded (0 = continuous)
//   bit_q        : index of the bit currently on the output
//   bit_d        : index of the bit that will be on the output next cycle
//   rep_q        : repetitions remaining, including the current one
module seq_bit_cnt
    import seq_pkg::*;
#(
    parameter int  PAT_W = SEQ_PAT_W,
    parameter int  REP_W = SEQ_REP_W,
    localparam int IDX_W = seq_idx_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [IDX_W-1:0] load_len_m1,
    input  logic [IDX_W-1:0] len_m1,
    input  logic [REP_W-1:0] load_rep,
    output logic [IDX_W-1:0] bit_q,
    output logic [IDX_W-1:0] bit_d,
    output logic [REP_W-1:0] rep_q
);

    logic [REP_W-1:0] rep_d;
    logic             wrap;

    // The bit index counts down to 0 and wraps back to len-1; each wrap ends
    // a repetition. A zero repetition count means continuous mode and is
    // never decremented.
    always_comb begin
        bit_d = bit_q;
        rep_d = rep_q;
        wrap  = advance && (bit_q == '0);
        if (load) begin
            bit_d = load_len_m1;
            rep_d = load_rep;
        end else if (wrap) begin
            bit_d = len_m1;
            if (rep_q != '0) begin
                rep_d = rep_q - REP_W'(1);
            end
        end else if (advance) begin
            bit_d = bit_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= '0;
            rep_q <= '0;
        end else begin
            bit_q <= bit_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern generator. A loaded pattern is emitted
// MSB-first (bit len-1 down to bit 0), repeated rep times, or continuously
// until stop when rep is 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load_valid  : load request, accepted when load_ready is high
//   load_ready  : generator is idle and can accept a load
//   pat_in      : pattern bits
//   len_in      : pattern length; 0 or > PAT_W means PAT_W
//   rep_in      : repetition count, 0 = continuous
//   stop        : finish the current repetition and end the emission
//   data_out    : serial bit
//   data_valid  : data_out carries a pattern bit
//   frame_start : first bit of each repetition
//   done        : one-cycle pulse after the emission ends
// Macro SEQ_GEN_GAP_EN inserts one idle cycle between repetitions.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int  PAT_W = SEQ_PAT_W,
    parameter int  REP_W = SEQ_REP_W,
    localparam int LEN_W = $clog2(PAT_W) + 1,
    localparam int IDX_W = seq_idx_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [REP_W-1:0] rep_in,
    input  logic             stop,
    output logic             data_out,
    output logic             data_valid,
    output logic             frame_start,
    output logic             done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   len_m1_q, len_m1_d;
    logic               stop_pend_q, stop_pend_d;
    logic               data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   in_len_m1;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [REP_W-1:0]   rep_q;
    logic               cnt_load;
    logic               advance;
    logic               finish_rep;

    assign load_ready = state_q[ST_IDLE_B];

    // Out-of-range lengths fall back to the full pattern width.
    always_comb begin
        if (len_in == '0 || len_in > LEN_W'(PAT_W)) begin
            in_len_m1 = IDX_W'(PAT_W - 1);
        end else begin
            in_len_m1 = IDX_W'(len_in - LEN_W'(1));
        end
    end

    seq_bit_cnt #(
        .PAT_W (PAT_W),
        .REP_W (REP_W)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load        (cnt_load),
        .advance     (advance),
        .load_len_m1 (in_len_m1),
        .len_m1      (len_m1_q),
        .load_rep    (rep_in),
        .bit_q       (bit_q),
        .bit_d       (bit_d),
        .rep_q       (rep_q)
    );

    // A repetition ends the emission when a stop has been seen during it
    // (including this very cycle) or when it was the last counted one.
    assign finish_rep = stop || stop_pend_q || (rep_q == REP_W'(1));

    // FSM next state plus capture of the load fields.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_m1_d    = len_m1_q;
        stop_pend_d = stop_pend_q;
        cnt_load    = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    pat_d       = pat_in;
                    len_m1_d    = in_len_m1;
                    stop_pend_d = 1'b0;
                    cnt_load    = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                advance = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (bit_q == '0) begin
                    if (finish_rep) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef SEQ_GEN_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_SHIFT;
`endif
                    end
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                // The previous repetition is already complete here, so a
                // stop simply ends the emission.
                state_d = (stop || stop_pend_q) ? ST_DONE : ST_SHIFT;
            end
`endif
            ST_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-cycle state and bit index so that
    // the first bit appears in the cycle right after the load is accepted.
    always_comb begin
        data_valid_d  = state_d[ST_SHIFT_B];
        data_out_d    = state_d[ST_SHIFT_B] && pat_d[bit_d];
        frame_start_d = state_d[ST_SHIFT_B] && (bit_d == len_m1_d);
        done_d        = state_d[ST_DONE_B];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pat_q         <= '0;
            len_m1_q      <= '0;
            stop_pend_q   <= 1'b0;
            data_out_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pat_q         <= pat_d;
            len_m1_q      <= len_m1_d;
            stop_pend_q   <= stop_pend_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 SHALL have parameter REP_W, default 4, width of repetition count.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  load request.
REQ-006 SHALL have port load_ready  output  1  generator can accept a load.
REQ-007 SHALL have port pat_in  input  PAT_W  pattern; bit [len-1] is sent first.
REQ-008 SHALL have port len_in  input  $clog2(PAT_W)+1  pattern length in bits.
REQ-009 SHALL have port rep_in  input  REP_W  repetition count; 0 = continuous.
REQ-010 SHALL have port stop  input  1  request end of continuous/remaining emission.
REQ-011 SHALL have port data_out  output  1  serial bit.
REQ-012 SHALL have port data_valid  output  1  data_out carries a pattern bit.
REQ-013 SHALL have port frame_start  output  1  high with first bit of each repetition.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of emission.

Function
REQ-015 SHALL implement one-hot FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL drive load_ready high only in IDLE; a load is accepted on load_valid && load_ready.
REQ-017 SHALL register pat_in, len_in, rep_in on acceptance; later input changes are ignored.
REQ-018 SHALL clamp len_in of 0 or greater than PAT_W to PAT_W.
REQ-019 SHALL present the first bit (pat[len-1]) with data_valid=1 and frame_start=1 in the cycle after acceptance.
REQ-020 SHALL emit one bit per cycle, MSB-first down to pat[0], all outputs registered.
REQ-021 SHALL restart the pattern immediately after pat[0] (no gap) while repetitions remain.
REQ-022 SHALL, for rep_in=N>0, emit exactly N*len bits, then enter DONE for one cycle with done=1, then IDLE.
REQ-023 SHALL, for rep_in=0, repeat until stop is sampled high, then finish the current repetition and go to DONE.
REQ-024 SHALL, with stop high during a counted emission, finish the current repetition and go to DONE, skipping the rest.
REQ-025 SHALL ignore stop in IDLE and DONE.
REQ-026 SHALL hold data_out=0, data_valid=0, frame_start=0 outside SHIFT.
REQ-027 SHALL wrap the bit counter from 0 to len-1 and decrement the remaining-repetition counter at each wrap.
REQ-028 SHALL treat load_valid during SHIFT/DONE as not accepted (load_ready=0); no queuing.

Reset
REQ-029 SHALL, on rst high at any time including mid-emission, enter IDLE immediately and drive load_ready=1 on the first cycle after release, data_out=0, data_valid=0, frame_start=0, done=0.
REQ-030 SHALL clear stored pattern, length and counters on reset.

Configuration
REQ-031 SHALL, with macro SEQ_GEN_GAP_EN defined, insert exactly one cycle with data_valid=0 between consecutive repetitions (state GAP); frame_start marks the bit after the gap.
REQ-032 SHALL, without SEQ_GEN_GAP_EN, emit repetitions back-to-back per REQ-021 and contain no GAP state.

Structure
REQ-033 SHALL place the state-encoding typedef/constants and the default PAT_W/REP_W in shared package seq_pkg, reused by the sequence detectors.
REQ-034 SHALL implement the bit and repetition counters in sub-module seq_bit_cnt; the shifter and FSM stay in the top module.

Verification
REQ-035 SHALL cover: pat_in=8'b0000_1101, len=4, rep=3 -> data_out 1101 1101 1101 over 12 consecutive valid cycles, frame_start on cycles 1/5/9, done 1 cycle after last bit.
REQ-036 SHALL cover: that stream fed into the 1101 detector -> three detections (overlap-free) with no spurious ones.
REQ-037 SHALL cover: len=0, pat=8'hA5, rep=1 -> 10100101 (8 bits), then done.
REQ-038 SHALL cover: rep=0, pat=1101, stop pulsed during 2nd repetition bit 2 -> exactly 8 bits emitted, then done.
REQ-039 SHALL cover: rst asserted at bit 3 of a rep=2 emission -> outputs zero next edge, load_ready=1 after release, new load 1011 emits correctly.
REQ-040 SHALL cover: SEQ_GEN_GAP_EN build, 1101 rep=2 -> 1101, one invalid cycle, 1101, done.
